// File: rtl/axi_lite_selftest_pkg.sv
// Shared definitions for the AXI4-Lite register self-test master.
//   st_e              : sweep state encoding
//   RESP_*            : AXI response codes
//   ERR_*             : first_err_code values
//   selftest_pattern  : test word for register idx, rotl(seed, idx mod w) ^ idx,
//                       evaluated in a 64-bit container and masked to w bits
package axi_lite_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WB, ST_RA, ST_RD, ST_NEXT, ST_DONE
  } st_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BRESP = 2'd1;
  localparam logic [1:0] ERR_RRESP = 2'd2;
  localparam logic [1:0] ERR_DATA  = 2'd3;

  function automatic logic [63:0] selftest_pattern(input logic [63:0] seed,
                                                   input logic [7:0]  idx,
                                                   input int unsigned w);
    logic [63:0] mask, s, r;
    int unsigned sh;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s    = seed & mask;
    sh   = 32'(idx) % w;
    // sh==0 is special-cased so the right shift never reaches w
    r    = (sh == 0) ? s : (((s << sh) | (s >> (w - sh))) & mask);
    return (r ^ {56'd0, idx}) & mask;
  endfunction

endpackage

// File: rtl/axi_lite_selftest_watchdog.sv
// Per-wait cycle counter for the self-test master.
//   ACLK, ARESETN : clock, async active-low reset
//   clr           : state change, restarts the count
//   en            : master is waiting on a channel
//   expired       : TIMEOUT cycles spent in the current wait
module axi_lite_selftest_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // The cycle that sees cnt==TIMEOUT-1 is the TIMEOUT-th waiting cycle.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)             cnt_q <= '0;
    else if (clr)             cnt_q <= '0;
    else if (en && !expired)  cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/axi_lite_reg_selftest.sv
// AXI4-Lite master running a write / read-back / compare sweep over NUM_REGS
// consecutive registers starting at BASE_ADDR, with seed-derived data.
//   start/pat_seed  : begin a sweep (ignored unless idle)
//   busy/done/pass  : sweep status; done is a one-cycle pulse
//   err_count       : failing registers (saturating), first_err_idx/code
//   timeout         : sweep aborted by the watchdog
//   M_AXI_*         : AXI4-Lite master channels
// Optional: define AXI_LITE_SELFTEST_TIMEOUT_EN to build the per-wait
// watchdog; otherwise every wait is unbounded and timeout stays 0.
module axi_lite_reg_selftest
  import axi_lite_selftest_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 255
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [DATA_W-1:0]               pat_seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [$clog2(NUM_REGS+1)-1:0]   err_count,
  output logic [7:0]                      first_err_idx,
  output logic [1:0]                      first_err_code,
  output logic                            timeout,
  output logic [ADDR_W-1:0]               M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [DATA_W-1:0]               M_AXI_WDATA,
  output logic [DATA_W/8-1:0]             M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [ADDR_W-1:0]               M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [DATA_W-1:0]               M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int                ECW      = $clog2(NUM_REGS + 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(DATA_W / 8);
  localparam logic [7:0]        LAST_IDX = 8'(NUM_REGS - 1);

  st_e               state_q, state_d;
  logic              aw_ok_q, w_ok_q, reg_err_q, pass_q, tmo_q;
  logic [DATA_W-1:0] seed_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        idx_q, fe_idx_q;
  logic [1:0]        fe_code_q;
  logic [ECW-1:0]    err_cnt_q, err_inc;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, start_acc, waiting, wd_expired;

  // VALID/READY decode straight from registered state, so they are glitch-free.
  assign M_AXI_AWVALID = (state_q == ST_WR) && !aw_ok_q;
  assign M_AXI_WVALID  = (state_q == ST_WR) && !w_ok_q;
  assign M_AXI_BREADY  = (state_q == ST_WB);
  assign M_AXI_ARVALID = (state_q == ST_RA);
  assign M_AXI_RREADY  = (state_q == ST_RD);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY  && M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY  && M_AXI_RVALID;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign waiting   = (state_q == ST_WR) || (state_q == ST_WB) ||
                     (state_q == ST_RA) || (state_q == ST_RD);
  assign err_inc   = (err_cnt_q == ECW'(NUM_REGS)) ? err_cnt_q : err_cnt_q + 1'b1;

  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_cnt_q;
  assign first_err_idx  = fe_idx_q;
  assign first_err_code = fe_code_q;

`ifdef AXI_LITE_SELFTEST_TIMEOUT_EN
  axi_lite_selftest_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (state_d != state_q),
    .en      (waiting),
    .expired (wd_expired)
  );
  assign timeout = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT[0], tmo_q};
  assign wd_expired     = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WR;
      // AW and W may complete in either order; the ok flags remember which did.
      ST_WR:   if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs)) state_d = ST_WB;
      ST_WB:   if (b_hs)  state_d = ST_RA;
      ST_RA:   if (ar_hs) state_d = ST_RD;
      ST_RD:   if (r_hs)  state_d = ST_NEXT;
      ST_NEXT: state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_WR;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A wait that makes no progress for TIMEOUT cycles abandons the sweep.
    if (wd_expired && (state_d == state_q)) state_d = ST_DONE;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ok_q <= 1'b0; w_ok_q <= 1'b0; reg_err_q <= 1'b0;
      pass_q  <= 1'b0; tmo_q  <= 1'b0;
      seed_q  <= '0;   wdata_q <= '0;  addr_q <= '0;
      idx_q   <= '0;   fe_idx_q <= '0; fe_code_q <= ERR_NONE;
      err_cnt_q <= '0;
    end else begin
      if (start_acc) begin
        seed_q    <= pat_seed;
        idx_q     <= '0;
        addr_q    <= BASE_ADDR;
        wdata_q   <= DATA_W'(selftest_pattern(64'(pat_seed), 8'd0, DATA_W));
        aw_ok_q   <= 1'b0; w_ok_q <= 1'b0; reg_err_q <= 1'b0;
        err_cnt_q <= '0;   fe_idx_q <= '0; fe_code_q <= ERR_NONE;
        pass_q    <= 1'b0; tmo_q <= 1'b0;
      end
      if (aw_hs) aw_ok_q <= 1'b1;
      if (w_hs)  w_ok_q  <= 1'b1;

      if (b_hs && (M_AXI_BRESP != RESP_OKAY)) begin
        reg_err_q <= 1'b1;
        err_cnt_q <= err_inc;
        if (err_cnt_q == '0) begin
          fe_idx_q  <= idx_q;
          fe_code_q <= ERR_BRESP;
        end
      end

      // A register already charged for its write is not charged again.
      if (r_hs && !reg_err_q &&
          ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != wdata_q))) begin
        err_cnt_q <= err_inc;
        if (err_cnt_q == '0) begin
          fe_idx_q  <= idx_q;
          fe_code_q <= (M_AXI_RRESP != RESP_OKAY) ? ERR_RRESP : ERR_DATA;
        end
      end

      if (state_q == ST_NEXT) begin
        aw_ok_q <= 1'b0; w_ok_q <= 1'b0; reg_err_q <= 1'b0;
        if (idx_q == LAST_IDX) begin
          pass_q <= (err_cnt_q == '0);
        end else begin
          idx_q   <= idx_q + 8'd1;
          addr_q  <= addr_q + STEP;
          wdata_q <= DATA_W'(selftest_pattern(64'(seed_q), idx_q + 8'd1, DATA_W));
        end
      end

      // Only the watchdog can take a waiting state straight to DONE.
      if (waiting && (state_d == ST_DONE)) begin
        tmo_q  <= 1'b1;
        pass_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_selftest.sv
// Self-checking bench for axi_lite_reg_selftest: a configurable RAM slave
// (AWREADY delay, write SLVERR, read EXOKAY, read-data bit flip, BVALID
// suppression) on the main instance, and a plain zero-wait slave on a second
// instance with a wrapping BASE_ADDR.
module tb_axi_lite_reg_selftest;
  import axi_lite_selftest_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  // ---------------- main instance ----------------
  logic        start;
  logic [31:0] pat_seed;
  logic        busy, done, pass, timeout;
  logic [2:0]  err_count;
  logic [7:0]  fe_idx;
  logic [1:0]  fe_code;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_reg_selftest #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(4),
                          .BASE_ADDR(32'h0), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .pat_seed(pat_seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(fe_idx), .first_err_code(fe_code), .timeout(timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready));

  // configurable RAM slave, register index = addr[5:2]
  logic [31:0] mem [16];
  int          aw_delay = 0, slverr_idx = -1, flip_idx = -1, rerr_idx = -1;
  bit          no_bvalid = 1'b0;
  logic [3:0]  aw_cnt;
  logic        aw_got, w_got, aw_hs, w_hs, a_have, d_have;
  logic [31:0] aw_l, w_l, a_eff, d_eff;

  assign awready = int'(aw_cnt) >= aw_delay;
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign a_have  = aw_got || aw_hs;
  assign d_have  = w_got || w_hs;
  assign a_eff   = aw_got ? aw_l : awaddr;
  assign d_eff   = w_got ? w_l : wdata;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= '0; aw_got <= 1'b0; w_got <= 1'b0; aw_l <= '0; w_l <= '0;
      bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (aw_hs)        aw_cnt <= '0;
      else if (awvalid) aw_cnt <= aw_cnt + 4'd1;
      if (a_have && d_have) begin
        mem[a_eff[5:2]] <= d_eff;
        aw_got <= 1'b0; w_got <= 1'b0;
        bvalid <= !no_bvalid;
        bresp  <= (int'(a_eff[5:2]) == slverr_idx) ? 2'b10 : RESP_OKAY;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_l <= awaddr; end
        if (w_hs)  begin w_got  <= 1'b1; w_l  <= wdata;  end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[5:2]] ^ ((int'(araddr[5:2]) == flip_idx) ? 32'd1 : 32'd0);
        rresp  <= (int'(araddr[5:2]) == rerr_idx) ? RESP_EXOKAY : RESP_OKAY;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- wrap-address instance ----------------
  logic        w_start, w_busy, w_done, w_pass, w_timeout;
  logic [2:0]  w_err_count;
  logic [7:0]  w_fe_idx;
  logic [1:0]  w_fe_code, w_bresp, w_rresp;
  logic [31:0] w_awaddr, w_wdata, w_araddr, w_rdata;
  logic [2:0]  w_awprot, w_arprot;
  logic [3:0]  w_wstrb;
  logic        w_awvalid, w_wvalid, w_bvalid, w_bready, w_arvalid, w_rvalid, w_rready;
  logic [31:0] wmem [4];
  logic [31:0] w_alog [4];
  logic [2:0]  w_n;

  axi_lite_reg_selftest #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(4),
                          .BASE_ADDR(32'hFFFF_FFF8), .TIMEOUT(255)) dut_wrap (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(w_start), .pat_seed(32'hCAFE_F00D),
    .busy(w_busy), .done(w_done), .pass(w_pass), .err_count(w_err_count),
    .first_err_idx(w_fe_idx), .first_err_code(w_fe_code), .timeout(w_timeout),
    .M_AXI_AWADDR(w_awaddr), .M_AXI_AWPROT(w_awprot), .M_AXI_AWVALID(w_awvalid),
    .M_AXI_AWREADY(1'b1), .M_AXI_WDATA(w_wdata), .M_AXI_WSTRB(w_wstrb),
    .M_AXI_WVALID(w_wvalid), .M_AXI_WREADY(1'b1), .M_AXI_BRESP(w_bresp),
    .M_AXI_BVALID(w_bvalid), .M_AXI_BREADY(w_bready), .M_AXI_ARADDR(w_araddr),
    .M_AXI_ARPROT(w_arprot), .M_AXI_ARVALID(w_arvalid), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(w_rdata), .M_AXI_RRESP(w_rresp), .M_AXI_RVALID(w_rvalid),
    .M_AXI_RREADY(w_rready));

  assign w_bresp = RESP_OKAY;
  assign w_rresp = RESP_OKAY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_bvalid <= 1'b0; w_rvalid <= 1'b0; w_rdata <= '0; w_n <= '0;
    end else begin
      if (w_awvalid && w_wvalid) begin
        wmem[w_awaddr[3:2]] <= w_wdata;
        w_alog[w_n[1:0]]    <= w_awaddr;
        w_n      <= w_n + 3'd1;
        w_bvalid <= 1'b1;
      end else if (w_bvalid && w_bready) begin
        w_bvalid <= 1'b0;
      end
      if (w_arvalid) begin
        w_rvalid <= 1'b1;
        w_rdata  <= wmem[w_araddr[3:2]];
      end else if (w_rvalid && w_rready) begin
        w_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0; tick(); tick(); ARESETN = 1'b1; tick();
  endtask

  function automatic logic any_out();
    return |{busy, done, pass, err_count, fe_idx, fe_code, timeout, awaddr, awvalid,
             wdata, wvalid, bready, araddr, arvalid, rready};
  endfunction

  // start at cycle 0, return the cycle index at which done is seen
  task automatic run(input logic [31:0] seed, output int cyc);
    pat_seed = seed; start = 1'b1; tick(); start = 1'b0; cyc = 1;
    while (!done && cyc < 300) begin tick(); cyc++; end
  endtask

  task automatic chk_mem(input string nm, input logic [31:0] seed);
    for (int i = 0; i < 4; i++)
      chk(nm, mem[i], selftest_pattern(64'(seed), 8'(i), 32) & 64'hFFFF_FFFF);
  endtask

  typedef struct {
    logic [31:0] seed;
    int aw_dly, slverr, flip, rerr;
    int exp_cyc, exp_err, exp_idx, exp_code;
    bit exp_pass;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog_guard
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    ARESETN = 1'b0; start = 1'b0; w_start = 1'b0; pat_seed = '0;
    vecs[0] = '{32'hDEADBEEF, 0, -1, -1, -1, 21, 0, 0, 0, 1'b1};
    vecs[1] = '{32'hA5A5_0F0F, 3, -1, -1, -1, 33, 0, 0, 0, 1'b1};
    vecs[2] = '{32'h1234_5678, 0,  2,  3, -1, 21, 2, 2, 1, 1'b0};
    vecs[3] = '{32'h0000_0000, 0, -1,  0, -1, 21, 1, 0, 3, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 0,  1,  1, -1, 21, 1, 1, 1, 1'b0};
    vecs[5] = '{32'h8000_0001, 0, -1, -1,  3, 21, 1, 3, 2, 1'b0};
    vecs[6] = '{32'h0F0F_0F0F, 0,  0,  3,  0, 21, 2, 0, 1, 1'b0};

    // reset state
    tick(); tick();
    chk("reset_outputs", any_out(), 1'b0);
    ARESETN = 1'b1; tick();
    chk("wstrb_prot", {wstrb, awprot, arprot}, {4'hF, 3'd0, 3'd0});

    // reference sweep with literal data
    run(32'h0101_FFFF, cyc);
    chk("ref_done_cycle", cyc, 21);
    chk("ref_busy_at_done", busy, 1'b0);
    chk("ref_pass", pass, 1'b1);
    chk("ref_err_count", err_count, 0);
    chk("ref_reg0", mem[0], 32'h0101_FFFF);
    chk("ref_reg1", mem[1], 32'h0203_FFFF);
    chk("ref_reg2", mem[2], 32'h0407_FFFE);
    chk("ref_reg3", mem[3], 32'h080F_FFFB);
    tick();
    chk("ref_done_pulse", {busy, done}, 2'b00);
    chk("ref_pass_held", pass, 1'b1);

    // AWREADY held off 3 cycles, WREADY immediate
    do_reset();
    aw_delay = 3;
    pat_seed = 32'h1111_2222; start = 1'b1; tick(); start = 1'b0;
    chk("awdly_c1_valids", {awvalid, wvalid}, 2'b11);
    tick();
    chk("awdly_c2_valids", {awvalid, wvalid}, 2'b10);
    chk("awdly_c2_addr", awaddr, 32'h0);
    tick(); tick();
    chk("awdly_c4_valids", {awvalid, wvalid}, 2'b10);
    tick();
    chk("awdly_c5_wb", {awvalid, bready}, 2'b01);
    cyc = 5;
    while (!done && cyc < 300) begin tick(); cyc++; end
    chk("awdly_done_cycle", cyc, 33);
    chk("awdly_pass", pass, 1'b1);
    chk_mem("awdly_mem", 32'h1111_2222);
    aw_delay = 0;

    // table of sweeps
    foreach (vecs[v]) begin
      do_reset();
      chk("tbl_reset_outputs", any_out(), 1'b0);
      aw_delay = vecs[v].aw_dly; slverr_idx = vecs[v].slverr;
      flip_idx = vecs[v].flip;   rerr_idx   = vecs[v].rerr;
      run(vecs[v].seed, cyc);
      chk($sformatf("tbl%0d_done_cycle", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("tbl%0d_err_count", v), err_count, vecs[v].exp_err);
      chk($sformatf("tbl%0d_first_idx", v), fe_idx, vecs[v].exp_idx);
      chk($sformatf("tbl%0d_first_code", v), fe_code, vecs[v].exp_code);
      chk($sformatf("tbl%0d_pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("tbl%0d_timeout", v), timeout, 1'b0);
      chk_mem($sformatf("tbl%0d_mem", v), vecs[v].seed);
    end
    aw_delay = 0; slverr_idx = -1; flip_idx = -1; rerr_idx = -1;

    // start during busy and in the DONE cycle are dropped
    do_reset();
    pat_seed = 32'h5555_AAAA; start = 1'b1; tick(); start = 1'b0; cyc = 1;
    tick(); tick(); cyc = 3;
    pat_seed = 32'h0; start = 1'b1; tick(); start = 1'b0; cyc = 4;
    while (!done && cyc < 300) begin tick(); cyc++; end
    chk("busy_start_done_cycle", cyc, 21);
    chk_mem("busy_start_mem", 32'h5555_AAAA);
    start = 1'b1; tick(); start = 1'b0;
    chk("done_start_dropped", {busy, done}, 2'b00);
    tick();
    chk("done_start_still_idle", busy, 1'b0);

    // reset pulsed during RD of register 1 (cycle 9), then a clean sweep
    do_reset();
    pat_seed = 32'h0101_FFFF; start = 1'b1; tick(); start = 1'b0;
    for (int i = 2; i <= 9; i++) tick();
    chk("rst_in_rd_state", {rready, araddr}, {1'b1, 32'h4});
    #2 ARESETN = 1'b0; #1;
    chk("rst_async_outputs", any_out(), 1'b0);
    tick(); ARESETN = 1'b1; tick();
    chk("rst_idle_after", any_out(), 1'b0);
    run(32'h1357_2468, cyc);
    chk("rst_rerun_cycle", cyc, 21);
    chk("rst_rerun_pass", {pass, err_count}, {1'b1, 3'd0});
    chk_mem("rst_rerun_mem", 32'h1357_2468);

    // wrapping base address on the second instance
    w_start = 1'b1; tick(); w_start = 1'b0; cyc = 1;
    while (!w_done && cyc < 300) begin tick(); cyc++; end
    chk("wrap_done_cycle", cyc, 21);
    chk("wrap_addr0", w_alog[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", w_alog[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", w_alog[2], 32'h0000_0000);
    chk("wrap_addr3", w_alog[3], 32'h0000_0004);
    chk("wrap_pass", w_pass, 1'b1);

`ifdef AXI_LITE_SELFTEST_TIMEOUT_EN
    // slave never answers the write: BREADY for 16 cycles, then abort
    begin
      int br;
      do_reset();
      no_bvalid = 1'b1; br = 0;
      pat_seed = 32'h7777_0000; start = 1'b1; tick(); start = 1'b0; cyc = 1;
      while (!done && cyc < 300) begin
        if (bready) br++;
        tick(); cyc++;
      end
      chk("tmo_bready_cycles", br, 16);
      chk("tmo_done_cycle", cyc, 18);
      chk("tmo_flags", {timeout, pass, bready}, 3'b100);
      no_bvalid = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_selftest.md
# axi_lite_reg_selftest

Synthesizable AXI4-Lite master that runs a built-in write/read-back/compare sweep over `NUM_REGS` consecutive slave registers, then reports pass/fail and error details. It sits beside the MSI generator register slave (or any AXI4-Lite register bank) on the same interconnect. It is the hardware successor of the simulation-only register check: word width, register count and base address are parametrised, test data is seed-derived, and failures are counted rather than halting.

## Interface
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: AXI data width. Must be 32 or 64.
- `NUM_REGS`, default 4: registers swept. Range 1..256.
- `BASE_ADDR`, default 0: address of register 0.
- `TIMEOUT`, default 255: cycles allowed per channel wait (used only with the macro).
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse that begins a sweep. Ignored while `busy`.
- `pat_seed`  in  DATA_W  pattern seed, sampled on `start`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  last sweep had zero errors. Valid from `done` until next `start`.
- `err_count`  out  $clog2(NUM_REGS+1)  failed registers, saturating.
- `first_err_idx`  out  8  index of the first failing register.
- `first_err_code`  out  2  failure type: 1 = bad BRESP, 2 = bad RRESP, 3 = data mismatch.
- `timeout`  out  1  sweep aborted by the watchdog.
- `M_AXI_AWADDR/AWPROT/AWVALID/AWREADY`, `M_AXI_WDATA/WSTRB/WVALID/WREADY`, `M_AXI_BRESP/BVALID/BREADY`, `M_AXI_ARADDR/ARPROT/ARVALID/ARREADY`, `M_AXI_RDATA/RRESP/RVALID/RREADY`: standard AXI4-Lite master channels. AWPROT and ARPROT are fixed to 0. WSTRB is all ones.

## Operation
- Register i has address `BASE_ADDR + i*(DATA_W/8)`. The sum is taken mod 2^ADDR_W.
- Register i has data `rotl(seed, i mod DATA_W) ^ i`, with i zero-extended to DATA_W.
- States and transitions:
  - IDLE → WR on `start`.
  - WR → WB once both AW and W have handshaken.
  - WB → RA on B handshake.
  - RA → RD on AR handshake.
  - RD → NEXT on R handshake.
  - NEXT → WR if more registers remain, else DONE.
  - DONE → IDLE after one cycle.
- Write (WR): AWVALID and WVALID assert together on WR entry. Each drops independently on its own handshake. The other may complete in the same cycle or later.
- BREADY is high only in WB. RREADY is high only in RD.
- Error detection:
  - BRESP ≠ 00 counts as an error for register i. The read-back still runs.
  - RRESP ≠ 00, or RDATA ≠ expected, counts as an error.
  - At most one error is counted per register. Priority for the recorded code: BRESP, then RRESP, then data.
- `first_err_*` is written only on the first error of a sweep. It is cleared to 0 on `start`.
- `err_count` clears on `start` and saturates at NUM_REGS.
- `pass = (err_count==0) && !timeout`.
- Reset values: all outputs 0, including every VALID/READY and `pass`.
- Reset asserted mid-sweep returns to IDLE immediately with all outputs at their reset values. No partial result is kept.

## Timing
- `start` at cycle 0 puts `busy`, AWVALID and WVALID high at cycle 1.
- Write path, zero-wait slave: AW/W handshake at 1, BVALID at 2, BREADY handshake at 2.
- Read path, zero-wait slave: ARVALID at 3, RVALID handshake at 4, NEXT at 5.
- Each register therefore takes 5 cycles with a zero-wait slave. A sweep takes `5*NUM_REGS + 1` cycles to `done`.
- `busy` falls in the same cycle that `done` pulses.
- Address and data outputs are registered and stay stable while their VALID is high.
- A `start` pulse during `busy` is dropped. A `start` in the DONE cycle is also dropped.

## Configuration
- `AXI_LITE_SELFTEST_TIMEOUT_EN` defined:
  - A per-wait counter clears on every state entry and counts while waiting in WR, WB, RA or RD.
  - Reaching `TIMEOUT` drops all VALID/READY outputs, sets `timeout`, and jumps to DONE.
  - This deliberately exits the AXI protocol and is treated as a fault condition only.
- Not defined: no counter is built, the block waits forever, and `timeout` is tied to 0.

## Structure
- Package `axi_lite_selftest_pkg` holds:
  - the state enum;
  - the AXI response constants (OKAY = 00, EXOKAY = 01);
  - the error-code constants;
  - the pattern function `selftest_pattern(seed, idx)`, shared with the bench as the reference model.
- One sub-module, `axi_lite_selftest_watchdog`, holds the timeout counter. It is instantiated only under the macro.

## Test plan
- Zero-wait RAM slave, seed 0x0101FFFF, NUM_REGS=4:
  - writes 0x0101FFFF, 0x0203FFFF, 0x0407FFFE, 0x080FFFFB to addresses 0x0, 0x4, 0x8, 0xC;
  - `done` pulses 21 cycles after `start`;
  - `pass`=1, `err_count`=0.
- Slave holds AWREADY low 3 cycles while WREADY is immediate → WVALID drops first, AWVALID stays high until its handshake, and the data is still correct.
- Slave returns SLVERR on the register-2 write and flips bit 0 of the register-3 read data:
  - `err_count`=2, `first_err_idx`=2, `first_err_code`=1;
  - `pass`=0.
- BASE_ADDR=0xFFFFFFF8, NUM_REGS=4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- ARESETN pulsed low during RD of register 1:
  - all outputs return to 0 asynchronously;
  - a new `start` runs a full clean sweep.
- With `AXI_LITE_SELFTEST_TIMEOUT_EN` and TIMEOUT=16, slave never asserts BVALID:
  - BREADY drops after 16 cycles in WB;
  - `timeout`=1, `pass`=0, `done` pulses.
